rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Shares the single register-file write port between several writeback producers (ALU, load/store unit, multi-cycle mul/div unit) using round-robin arbitration and a registered write stage. Optionally tracks outstanding destination registers in a scoreboard so decode can stall on RAW/WAW hazards. Sits between the execute/memory writeback sources and the register file's `we/rd/wdata` inputs.

## Interface
- `N_REQ`, 3: number of writeback requesters; index 0 = ALU, 1 = LSU, 2 = MDU.
- `XLEN`, 32: data width.
- `RAW`, 5: register address width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  N_REQ  requester i has a write pending.
- `req_ready`  out  N_REQ  requester i's write accepted this cycle (one-hot or zero).
- `req_rd`  in  N_REQ*RAW  destination per requester, packed, requester i at bits `[i*RAW +: RAW]`.
- `req_wdata`  in  N_REQ*XLEN  write data per requester, packed likewise.
- `rf_we`  out  1  register-file write enable.
- `rf_rd`  out  RAW  register-file write address.
- `rf_wdata`  out  XLEN  register-file write data.
- `iss_valid`  in  1  decode issuing an instruction that writes `iss_rd`.
- `iss_rd`  in  RAW  destination of the issuing instruction.
- `iss_ready`  out  1  issue allowed (no WAW on `iss_rd`).
- `rs1`, `rs2`  in  RAW  each: source registers of the instruction in decode.
- `rs1_busy`, `rs2_busy`  out  1  each: source has an outstanding write.

## Operation
- Handshake: a transfer occurs when `req_valid[i] && req_ready[i]`. Requester holds `req_rd`/`req_wdata` stable while valid and not ready.
- Arbitration: round-robin. Pointer `rr_ptr` (0..N_REQ-1) names the highest-priority requester; search order `rr_ptr, rr_ptr+1, …` mod N_REQ. At most one `req_ready` bit high; `req_ready` is combinational from `req_valid` and `rr_ptr`.
- On grant to i: `rr_ptr <= (i+1) mod N_REQ`. No grant: `rr_ptr` unchanged.
- Write stage: the granted `rd`/`wdata` are registered into `rf_rd`/`rf_wdata`; `rf_we` is 1 the following cycle if granted `rd != 0`, else 0. The RF accepts a write every cycle, so the stage never back-pressures.
- `rd == 0` requests: accepted (ready asserted, pointer advances), produce no write and no scoreboard effect.
- Idle cycle (no grant): `rf_we = 0`; `rf_rd`/`rf_wdata` hold their previous values.
- Scoreboard (see Configuration): `pending[31:1]`, bit 0 constant 0.
  - Set: `iss_valid && iss_ready && iss_rd != 0` sets `pending[iss_rd]`.
  - Clear: `rf_we` clears `pending[rf_rd]`.
  - Same register set and cleared in one cycle: set wins.
  - `iss_ready = !pending[iss_rd] || iss_rd == 0`; a pending register being cleared this cycle still counts as pending.
  - `rsN_busy = pending[rsN]`; 0 for `rsN == 0`.

## Timing
- Reset values: `rf_we = 0`, `rf_rd = 0`, `rf_wdata = 0`, `rr_ptr = 0`, `pending = 0`. While `rst` is high, `req_ready = 0` and `iss_ready = 0`.
- Latency: accept at cycle t → `rf_we` at t+1 → pending bit clear from t+2. The RF captures the write within cycle t+1, so a read in t+2 sees the new value.
- Throughput: one write per cycle total. Under full load each requester is served once every N_REQ cycles.
- Reset during operation discards the registered write (`rf_we` 0 in the next cycle) and all pending bits. Requesters' valids are their own responsibility.

## Configuration
- `RF_WB_SCOREBOARD_EN` defined: scoreboard, `iss_ready`, and `rsN_busy` behave as in Operation.
- `RF_WB_SCOREBOARD_EN` not defined: no `pending` storage. `iss_ready = !rst`, `rs1_busy = rs2_busy = 0`. Ports remain present.

## Structure
- Shared package `rf_wb_pkg`: `RAW`/`XLEN` defaults, requester index constants (`WB_ALU=0`, `WB_LSU=1`, `WB_MDU=2`), and a `wb_req_t` typedef holding rd and wdata.
- One sub-module, `rr_arbiter`: parameterised N-way round-robin grant. Inputs are the request vector and pointer; outputs are a one-hot grant and the granted index.
- Write stage and scoreboard live in the top module.

## Test plan
- Reset: assert `rst` with all valids high → `req_ready = 0`, `rf_we = 0`. Release → first grant goes to requester 0.
- Contention: all three valid for 6 cycles → grants 0,1,2,0,1,2. Each is followed one cycle later by `rf_we = 1` with the matching `rd`/`wdata` (e.g. x5 = 0xDEADBEEF).
- x0 drop: requester 1 valid with `rd = 0`, `wdata = 0x1234` → `req_ready[1] = 1`, `rf_we` stays 0, pointer moves to 2.
- Scoreboard RAW: issue `iss_rd = 7`, then `rs1 = 7` → `rs1_busy = 1`. The MDU writes x7 after 10 cycles; `rs1_busy` is 0 two cycles after acceptance.
- WAW and simultaneous events: with x9 pending, `iss_rd = 9` → `iss_ready = 0`. Issue x9 in the same cycle that `rf_we` commits x9 → `iss_ready = 0`; on the next cycle the issue succeeds and x9 stays pending.
- Reset mid-operation: assert `rst` one cycle after a grant with 3 pending bits set → `rf_we = 0` next cycle, all busy bits 0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared constants and types for the register-file writeback arbiter
package rf_wb_pkg;

   localparam int RF_RAW  = 5;
   localparam int RF_XLEN = 32;

   // Requester indices on the shared writeback port
   localparam int WB_ALU = 0;
   localparam int WB_LSU = 1;
   localparam int WB_MDU = 2;

   typedef struct packed {
      logic [RF_RAW-1:0]  rd;
      logic [RF_XLEN-1:0] wdata;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rtl/rf_wb_arbiter_rr.sv - N-way round-robin grant starting the search at ptr
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic found;
   int   idx;

   // First requester found walking ptr, ptr+1, ... wins; at most one grant bit
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin RF writeback arbiter, registered write stage, optional RF_WB_SCOREBOARD_EN hazard scoreboard
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int XLEN  = RF_XLEN,
   parameter int RAW   = RF_RAW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*RAW-1:0]  req_rd,
   input  logic [N_REQ*XLEN-1:0] req_wdata,
   output logic                  rf_we,
   output logic [RAW-1:0]        rf_rd,
   output logic [XLEN-1:0]       rf_wdata,
   input  logic                  iss_valid,
   input  logic [RAW-1:0]        iss_rd,
   output logic                  iss_ready,
   input  logic [RAW-1:0]        rs1,
   input  logic [RAW-1:0]        rs2,
   output logic                  rs1_busy,
   output logic                  rs2_busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    rr_ptr;
   logic [N_REQ-1:0] arb_req;
   logic [N_REQ-1:0] grant;
   logic [PW-1:0]    grant_idx;
   logic             granted;
   logic [RAW-1:0]   grant_rd;
   logic [XLEN-1:0]  grant_wdata;

   // No requester is accepted while reset is held
   assign arb_req   = rst ? '0 : req_valid;
   assign req_ready = grant;
   assign granted   = |grant;

   assign grant_rd    = req_rd[int'(grant_idx)*RAW +: RAW];
   assign grant_wdata = req_wdata[int'(grant_idx)*XLEN +: XLEN];

   rr_arbiter #(
      .N  (N_REQ),
      .IW (PW)
   ) u_rr (
      .req       (arb_req),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Priority pointer moves just past the requester that was served
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if (granted)
         rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PW'(1);
   end

   // Write stage: register the granted write; x0 writes are swallowed here
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_wdata <= '0;
      end else if (granted) begin
         rf_we    <= (grant_rd != '0);
         rf_rd    <= grant_rd;
         rf_wdata <= grant_wdata;
      end else begin
         rf_we    <= 1'b0;
      end
   end

`ifdef RF_WB_SCOREBOARD_EN
   localparam int NREG = 1 << RAW;

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;

   // A register being retired this cycle still blocks a new issue to it
   assign iss_ready = !rst && !pending[iss_rd];
   assign rs1_busy  = pending[rs1];
   assign rs2_busy  = pending[rs2];

   // Clear on commit, then set on issue so a same-cycle set wins; x0 never tracked
   always_comb begin
      pending_nxt = pending;
      if (rf_we)
         pending_nxt[rf_rd] = 1'b0;
      if (iss_valid && iss_ready && (iss_rd != '0))
         pending_nxt[iss_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Pending-destination register
   always_ff @(posedge clk) begin
      if (rst)
         pending <= '0;
      else
         pending <= pending_nxt;
   end
`else
   logic unused_sb;

   assign unused_sb = ^{iss_valid, iss_rd, rs1, rs2};
   assign iss_ready = !rst;
   assign rs1_busy  = 1'b0;
   assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized scoreboard bench for rf_wb_arbiter (follows RF_WB_SCOREBOARD_EN)
module tb_rf_wb_arbiter;
   import rf_wb_pkg::*;

   localparam int N  = 3;
   localparam int RW = RF_RAW;
   localparam int XL = RF_XLEN;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*RW-1:0] req_rd;
   logic [N*XL-1:0] req_wdata;
   logic            rf_we;
   logic [RW-1:0]   rf_rd;
   logic [XL-1:0]   rf_wdata;
   logic            iss_valid;
   logic [RW-1:0]   iss_rd;
   logic            iss_ready;
   logic [RW-1:0]   rs1, rs2;
   logic            rs1_busy, rs2_busy;

   logic [RW-1:0]   s_rd [N];
   logic [XL-1:0]   s_wd [N];

   typedef struct {
      wb_req_t r;
      logic    we;
      int      cyc;
   } exp_t;

   exp_t         q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   bit           running = 1'b0;
   int           m_ptr = 0;
   bit           pend [32];
   bit           cur_we = 1'b0;
   logic [RW-1:0] cur_rd = '0;
   logic [N-1:0] acc = '0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_rd    = '0;
      req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         req_rd[i*RW +: RW]    = s_rd[i];
         req_wdata[i*XL +: XL] = s_wd[i];
      end
   end

   rf_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rd    (req_rd),
      .req_wdata (req_wdata),
      .rf_we     (rf_we),
      .rf_rd     (rf_rd),
      .rf_wdata  (rf_wdata),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle the RF port must show exactly what the scoreboard queued for it
   logic [RW-1:0] h_rd = '0;
   logic [XL-1:0] h_wd = '0;
   logic          e_we;
   exp_t          e;
   always @(negedge clk) begin
      if (running) begin
         e_we = 1'b0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e    = q.pop_front();
            e_we = e.we;
            h_rd = e.r.rd;
            h_wd = e.r.wdata;
         end
         chk("rf_we", 64'(rf_we), 64'(e_we));
         chk("rf_rd", 64'(rf_rd), 64'(h_rd));
         chk("rf_wdata", 64'(rf_wdata), 64'(h_wd));
      end
   end

   // One clock of reference model: check combinational outputs, predict next-cycle effects
   task automatic step();
      int gi;
      int idx;
      logic [N-1:0] er;
      logic ei, eb1, eb2;
      exp_t ne;
      @(negedge clk);
      gi = -1;
      er = '0;
      if (!rst)
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (gi < 0 && req_valid[idx]) gi = idx;
         end
      if (gi >= 0) er[gi] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
`ifdef RF_WB_SCOREBOARD_EN
      ei  = !rst && (iss_rd == 0 || !pend[iss_rd]);
      eb1 = pend[rs1];
      eb2 = pend[rs2];
`else
      ei  = !rst;
      eb1 = 1'b0;
      eb2 = 1'b0;
`endif
      chk("iss_ready", 64'(iss_ready), 64'(ei));
      chk("rs1_busy", 64'(rs1_busy), 64'(eb1));
      chk("rs2_busy", 64'(rs2_busy), 64'(eb2));
      if (rst) begin
         ne.r.rd = '0; ne.r.wdata = '0; ne.we = 1'b0; ne.cyc = cyc + 1;
         q.push_back(ne);
         m_ptr = 0;
      end else if (gi >= 0) begin
         ne.r.rd = s_rd[gi]; ne.r.wdata = s_wd[gi]; ne.we = (s_rd[gi] != 0); ne.cyc = cyc + 1;
         q.push_back(ne);
         m_ptr = (gi + 1) % N;
      end
      if (rst) begin
         foreach (pend[r]) pend[r] = 1'b0;
      end else begin
         if (cur_we) pend[cur_rd] = 1'b0;
         if (iss_valid && ei && iss_rd != 0) pend[iss_rd] = 1'b1;
      end
      cur_we = !rst && gi >= 0 && s_rd[gi] != 0;
      cur_rd = (gi >= 0) ? s_rd[gi] : '0;
      acc    = er;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [RW-1:0] rd, input logic [XL-1:0] wd);
      s_rd[i] = rd;
      s_wd[i] = wd;
   endtask

   initial begin
      running   = 1'b1;
      iss_valid = 1'b0;
      iss_rd    = '0;
      rs1       = '0;
      rs2       = '0;
      foreach (pend[r]) pend[r] = 1'b0;

      // Reset with every requester asking
      req_valid = '1;
      set_req(WB_ALU, 5, 32'hDEADBEEF);
      set_req(WB_LSU, 6, 32'h11111111);
      set_req(WB_MDU, 7, 32'h22222222);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Full contention for six cycles
      repeat (6) begin
         step();
         for (int i = 0; i < N; i++)
            if (acc[i]) set_req(i, RW'($urandom_range(1, 31)), $urandom());
      end

      // x0 write from the LSU, then everyone asks again
      req_valid = 3'b010;
      set_req(WB_LSU, 0, 32'h1234);
      step();
      req_valid = 3'b111;
      set_req(WB_LSU, 3, 32'hCAFE0003);
      step();
      req_valid = '0;
      step();

      // RAW on x7: issue, observe busy, MDU commits after ten cycles
      iss_valid = 1'b1; iss_rd = 7;
      step();
      iss_valid = 1'b0; rs1 = 7; rs2 = 3;
      repeat (10) step();
      req_valid = 3'b100;
      set_req(WB_MDU, 7, 32'h0BADF00D);
      step();
      req_valid = '0;
      repeat (3) step();

      // WAW on x9, including issue in the commit cycle
      iss_valid = 1'b1; iss_rd = 9;
      step();
      step();
      req_valid = 3'b100;
      set_req(WB_MDU, 9, 32'h99999999);
      step();
      req_valid = '0;
      step();
      step();
      iss_valid = 1'b0; rs1 = 9;
      step();

      // Reset one cycle after a grant, with three registers pending
      for (int r = 10; r < 13; r++) begin
         iss_valid = 1'b1; iss_rd = RW'(r);
         step();
      end
      iss_valid = 1'b0;
      req_valid = 3'b001;
      set_req(WB_ALU, 10, 32'hA0A0A0A0);
      step();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0; rs1 = 11; rs2 = 12;
      step();
      step();

      // Randomized traffic, issues and occasional resets
      for (int i = 0; i < N; i++) set_req(i, RW'($urandom_range(0, 12)), $urandom());
      repeat (600) begin
         rst       = ($urandom_range(0, 59) == 0);
         iss_valid = $urandom_range(0, 1);
         iss_rd    = RW'($urandom_range(0, 12));
         rs1       = RW'($urandom_range(0, 12));
         rs2       = RW'($urandom_range(0, 12));
         step();
         for (int i = 0; i < N; i++)
            if (acc[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 9) < 6);
               set_req(i, ($urandom_range(0, 6) == 0) ? '0 : RW'($urandom_range(1, 12)), $urandom());
            end
      end

      rst = 1'b0; req_valid = '0; iss_valid = 1'b0;
      step();
      step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
      end
      running = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
